// File: rtl/bw_to_gray_unpacker_pkg.sv
// Shared definitions for the binary<->gray pixel paths (threshold/packer and
// unpacker): pixel/byte widths, FSM state encoding, bit-to-level mapping.
package bw_to_gray_unpacker_pkg;

  localparam int GRAY_W = 8;
  localparam int PACK_W = 8;

  // FSM encoding kept as plain constants so older tools can share it.
  localparam logic [0:0] ST_IDLE = 1'b0;  // no pixel held
  localparam logic [0:0] ST_EMIT = 1'b1;  // shift reg holds pending pixels

  // A 0 pixel becomes the low level, a 1 pixel the high level.
  function automatic logic [GRAY_W-1:0] bit_to_gray(input logic              b,
                                                     input logic [GRAY_W-1:0] lo,
                                                     input logic [GRAY_W-1:0] hi);
    return b ? hi : lo;
  endfunction

endpackage

// File: rtl/bw_to_gray_unpacker_line_counter.sv
// Column counter for a pixel line: counts transferred pixels, wraps at
// LINE_WIDTH-1, and flags whether the next pixel to be presented is the
// last one of the line.
module bw_line_counter #(
  parameter int LINE_WIDTH = 640
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic i_adv,
  output logic o_last_nxt
);

  localparam int            CW   = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(LINE_WIDTH - 1);

  logic [CW-1:0] r_col;
  logic [CW-1:0] w_col_nxt;

  // Column the next presented pixel will occupy (this cycle's advance applied).
  always_comb begin
    w_col_nxt = r_col;
    if (i_adv) w_col_nxt = (r_col == LAST) ? '0 : r_col + CW'(1);
  end

  assign o_last_nxt = (w_col_nxt == LAST);

  // Advance per transferred pixel; frozen when the block is disabled.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)     r_col <= '0;
    else if (en_i)  r_col <= w_col_nxt;
  end

endmodule

// File: rtl/bw_to_gray_unpacker.sv
// Expands packed binary pixels (8 per byte) into 8-bit gray pixels with
// valid/ready on both sides. A line end cuts the current byte short so every
// line starts on a byte boundary.
module bw_to_gray_unpacker
  import bw_to_gray_unpacker_pkg::*;
#(
  parameter int LINE_WIDTH = 640,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [PACK_W-1:0] veri_i,
  input  logic              veri_valid_i,
  output logic              veri_ready_o,
  input  logic [GRAY_W-1:0] low_level_i,
  input  logic [GRAY_W-1:0] high_level_i,
  output logic [GRAY_W-1:0] veri_o,
  output logic              veri_valid_o,
  input  logic              veri_ready_i,
  output logic              line_end_o
);

  logic [0:0]        r_state;
  logic [PACK_W-1:0] r_shift;
  logic [GRAY_W-1:0] r_lo;
  logic [GRAY_W-1:0] r_hi;
  logic [GRAY_W-1:0] r_veri;
  logic [3:0]        r_bits_left;  // pixels of the byte not yet transferred, incl. veri_o
  logic              r_valid;
  logic              r_line_end;

  logic              w_xfer;
  logic              w_last_px;
  logic              w_accept;
  logic              w_last_nxt;
  logic              w_first_bit;
  logic              w_next_bit;
  logic [PACK_W-1:0] w_in_rest;
  logic [PACK_W-1:0] w_sh_rest;

  assign w_xfer    = en_i & r_valid & veri_ready_i;
  // A byte finishes on its 8th pixel or early on a line end.
  assign w_last_px = w_xfer & ((r_bits_left == 4'd1) | r_line_end);

  assign veri_ready_o = rst_i & en_i & ((r_state == ST_IDLE) | w_last_px);
  assign w_accept     = en_i & veri_valid_i & veri_ready_o;

  assign w_first_bit = MSB_FIRST ? veri_i[PACK_W-1]  : veri_i[0];
  assign w_next_bit  = MSB_FIRST ? r_shift[PACK_W-1] : r_shift[0];
  assign w_in_rest   = MSB_FIRST ? {veri_i[PACK_W-2:0], 1'b0}  : {1'b0, veri_i[PACK_W-1:1]};
  assign w_sh_rest   = MSB_FIRST ? {r_shift[PACK_W-2:0], 1'b0} : {1'b0, r_shift[PACK_W-1:1]};

  bw_line_counter #(.LINE_WIDTH(LINE_WIDTH)) u_line_counter (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en_i       (en_i),
    .i_adv      (w_xfer),
    .o_last_nxt (w_last_nxt)
  );

  // FSM + shift reg: load a byte (first pixel straight to the output
  // register), step one pixel per transfer, drop to IDLE when the byte ends.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_lo        <= '0;
      r_hi        <= '0;
      r_veri      <= '0;
      r_bits_left <= '0;
      r_valid     <= 1'b0;
      r_line_end  <= 1'b0;
    end else if (en_i) begin
      if (w_accept) begin
        r_state     <= ST_EMIT;
        r_lo        <= low_level_i;
        r_hi        <= high_level_i;
        r_veri      <= bit_to_gray(w_first_bit, low_level_i, high_level_i);
        r_shift     <= w_in_rest;
        r_bits_left <= 4'd8;
        r_valid     <= 1'b1;
        r_line_end  <= w_last_nxt;
      end else if (w_last_px) begin
        r_state     <= ST_IDLE;
        r_shift     <= '0;
        r_bits_left <= '0;
        r_valid     <= 1'b0;
        r_line_end  <= 1'b0;
      end else if (w_xfer) begin
        r_veri      <= bit_to_gray(w_next_bit, r_lo, r_hi);
        r_shift     <= w_sh_rest;
        r_bits_left <= r_bits_left - 4'd1;
        r_line_end  <= w_last_nxt;
      end
    end
  end

  assign veri_o       = r_veri;
  assign veri_valid_o = r_valid;
  assign line_end_o   = r_line_end;

endmodule

// File: tb/tb_bw_to_gray_unpacker.sv
// Directed bench: three unpacker instances (16-wide MSB-first, 10-wide
// MSB-first, 16-wide LSB-first) sharing clock, reset, enable, data, levels
// and downstream ready; each has its own upstream valid.
module tb_bw_to_gray_unpacker;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       en_i;
  logic [7:0] data;
  logic [7:0] lo;
  logic [7:0] hi;
  logic       ready_i;

  logic       vin [3];
  logic       rdy [3];
  logic [7:0] vo  [3];
  logic       vvo [3];
  logic       le  [3];

  int nvec = 0;
  int nerr = 0;

  logic [7:0] q_b [$];
  logic [7:0] q_ev[$];
  logic       q_le[$];

  always #5 clk_i = ~clk_i;

  bw_to_gray_unpacker #(.LINE_WIDTH(16), .MSB_FIRST(1'b1)) u_dut16 (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .veri_i(data), .veri_valid_i(vin[0]),
    .veri_ready_o(rdy[0]), .low_level_i(lo), .high_level_i(hi), .veri_o(vo[0]),
    .veri_valid_o(vvo[0]), .veri_ready_i(ready_i), .line_end_o(le[0]));

  bw_to_gray_unpacker #(.LINE_WIDTH(10), .MSB_FIRST(1'b1)) u_dut10 (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .veri_i(data), .veri_valid_i(vin[1]),
    .veri_ready_o(rdy[1]), .low_level_i(lo), .high_level_i(hi), .veri_o(vo[1]),
    .veri_valid_o(vvo[1]), .veri_ready_i(ready_i), .line_end_o(le[1]));

  bw_to_gray_unpacker #(.LINE_WIDTH(16), .MSB_FIRST(1'b0)) u_lsb (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .veri_i(data), .veri_valid_i(vin[2]),
    .veri_ready_o(rdy[2]), .low_level_i(lo), .high_level_i(hi), .veri_o(vo[2]),
    .veri_valid_o(vvo[2]), .veri_ready_i(ready_i), .line_end_o(le[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Feeds q_b into instance sel and checks every presented pixel against
  // q_ev/q_le. Optional 3-cycle downstream stall at pixel stall_at and level
  // switch to 0/255 once pixel chg_at is presented. Called at/after negedge.
  task automatic stream(input int sel, input int stall_at, input int chg_at, input string tag);
    int   bi = 0;
    int   k = 0;
    int   cyc = 0;
    int   stall_n = 0;
    logic acc;
    while (k < q_ev.size() && cyc < 400) begin
      if (k == chg_at) begin lo = 8'd0; hi = 8'd255; end
      ready_i = !(k == stall_at && stall_n < 3);
      vin[sel] = (bi < q_b.size());
      data     = (bi < q_b.size()) ? q_b[bi] : 8'h00;
      #1;
      acc = vin[sel] & rdy[sel];
      if (vvo[sel]) begin
        chk($sformatf("%s_px%0d", tag, k), vo[sel], q_ev[k]);
        chk($sformatf("%s_le%0d", tag, k), le[sel], q_le[k]);
        if (!ready_i) begin
          chk($sformatf("%s_stall_rdy%0d", tag, stall_n), rdy[sel], 0);
          stall_n++;
        end else begin
          k++;
        end
      end
      @(posedge clk_i);
      if (acc) bi++;
      cyc++;
      @(negedge clk_i);
    end
    vin[sel] = 1'b0;
    ready_i  = 1'b1;
    chk($sformatf("%s_count", tag), k, q_ev.size());
    #1;
    chk($sformatf("%s_idle", tag), vvo[sel], 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b0; en_i = 1'b1; data = 8'h00; lo = 8'd0; hi = 8'd255; ready_i = 1'b1;
    for (int i = 0; i < 3; i++) vin[i] = 1'b0;

    // Reset state
    repeat (2) @(negedge clk_i);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_vo%0d", i),  vo[i],  0);
      chk($sformatf("rst_vvo%0d", i), vvo[i], 0);
      chk($sformatf("rst_le%0d", i),  le[i],  0);
      chk($sformatf("rst_rdy%0d", i), rdy[i], 0);
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);

    // 1: A5,0F on 16-wide line, MSB first
    q_b  = '{8'hA5, 8'h0F};
    q_ev = '{8'd255, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd255,
             8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd255, 8'd255};
    q_le = '{0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,1};
    stream(0, -1, -1, "t1");

    // 2: LSB first, byte 01
    @(negedge clk_i);
    q_b  = '{8'h01};
    q_ev = '{8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    q_le = '{0,0,0,0,0,0,0,0};
    stream(2, -1, -1, "t2");

    // 3: 10-wide line, FF,FF,00: line end cuts second byte after 2 pixels
    @(negedge clk_i);
    q_b  = '{8'hFF, 8'hFF, 8'h00};
    q_ev = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255,
             8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    q_le = '{0,0,0,0,0,0,0,0,0,1, 0,0,0,0,0,0,0,0};
    stream(1, -1, -1, "t3");

    // 4: downstream stall 3 cycles at pixel 4
    @(negedge clk_i);
    q_b  = '{8'h3C, 8'hC3};
    q_ev = '{8'd0, 8'd0, 8'd255, 8'd255, 8'd255, 8'd255, 8'd0, 8'd0,
             8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd255};
    q_le = '{0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,1};
    stream(0, 4, -1, "t4");

    // 5: levels 16/200, switched to 0/255 mid-byte
    @(negedge clk_i);
    lo = 8'd16; hi = 8'd200;
    q_b  = '{8'hAA, 8'h55};
    q_ev = '{8'd200, 8'd16, 8'd200, 8'd16, 8'd200, 8'd16, 8'd200, 8'd16,
             8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255};
    q_le = '{0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,1};
    stream(0, -1, 3, "t5");

    // 6: enable low freezes, then reset mid-byte restarts the column
    lo = 8'd0; hi = 8'd255; ready_i = 1'b1;
    @(negedge clk_i);
    data = 8'hFF; vin[0] = 1'b1;
    #1;
    chk("t6_rdy_idle", rdy[0], 1);
    @(posedge clk_i);
    @(negedge clk_i);
    vin[0] = 1'b0; en_i = 1'b0;
    #1;
    chk("t6_first_vo", vo[0], 255);
    chk("t6_first_vvo", vvo[0], 1);
    chk("t6_first_rdy", rdy[0], 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      #1;
      chk($sformatf("t6_frz_vo%0d", i),  vo[0],  255);
      chk($sformatf("t6_frz_vvo%0d", i), vvo[0], 1);
      chk($sformatf("t6_frz_rdy%0d", i), rdy[0], 0);
    end
    en_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    #1;
    chk("t6_resume_vvo", vvo[0], 1);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("t6_rst_vo",  vo[0],  0);
    chk("t6_rst_vvo", vvo[0], 0);
    chk("t6_rst_le",  le[0],  0);
    chk("t6_rst_rdy", rdy[0], 0);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    q_b  = '{8'hFF, 8'h00};
    q_ev = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255,
             8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    q_le = '{0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,1};
    stream(0, -1, -1, "t6_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
